// File: rtl/audio_top_if.sv
// Codec FIFO-side audio bus: the two availability flags, the pop/push strobes and the stereo sample pairs.
interface audio_top_if;
    logic               audio_in_available;
    logic               audio_out_allowed;
    logic signed [31:0] audio_in_L;
    logic signed [31:0] audio_in_R;
    logic               read_audio_in;
    logic               write_audio_out;
    logic signed [31:0] audio_out_L;
    logic signed [31:0] audio_out_R;

    // Codec side: offers samples and space, receives strobes and processed samples.
    modport master (
        output audio_in_available, audio_out_allowed, audio_in_L, audio_in_R,
        input  read_audio_in, write_audio_out, audio_out_L, audio_out_R
    );

    modport slave (
        input  audio_in_available, audio_out_allowed, audio_in_L, audio_in_R,
        output read_audio_in, write_audio_out, audio_out_L, audio_out_R
    );
endinterface

// File: rtl/audio_top.sv
// Zero-latency stereo passthrough with SW[0] mute and a windowed peak meter on LEDR.
// Optional AUDIO_ATTEN_EN macro: unmuted samples are arithmetically shifted right by SW[3:1].
module audio_top #(
    parameter int METER_WINDOW = 4096
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [9:0]  SW,
    audio_top_if.slave  aud,
    output logic [9:0]  LEDR
);
    localparam int CW = (METER_WINDOW > 1) ? $clog2(METER_WINDOW) : 1;

    logic               w_xfer;
    logic signed [31:0] w_out_l;
    logic signed [31:0] w_out_r;
    logic [31:0]        w_mag;
    logic [31:0]        w_peak_next;
    logic [9:0]         w_therm;
    logic               w_sw_unused;

    logic [CW-1:0]      r_count;
    logic [31:0]        r_peak;
    logic [9:0]         r_ledr;

    assign w_xfer              = aud.audio_in_available & aud.audio_out_allowed;
    assign aud.read_audio_in   = w_xfer;
    assign aud.write_audio_out = w_xfer;
    assign aud.audio_out_L     = w_out_l;
    assign aud.audio_out_R     = w_out_r;
    assign LEDR                = r_ledr;

`ifdef AUDIO_ATTEN_EN
    assign w_sw_unused = ^SW[9:4];
`else
    assign w_sw_unused = ^SW[9:1];
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_out_l = aud.audio_in_L;
        w_out_r = aud.audio_in_R;
`ifdef AUDIO_ATTEN_EN
        w_out_l = aud.audio_in_L >>> SW[3:1];
        w_out_r = aud.audio_in_R >>> SW[3:1];
`endif
        // Mute is applied last so it overrides every other switch function.
        if (SW[0]) begin
            w_out_l = '0;
            w_out_r = '0;
        end
    end

    // Only the left channel is metered; the most negative value has no positive twin, so it saturates.
    always_comb begin
        w_mag = w_out_l;
        if (w_out_l == 32'sh8000_0000) begin
            w_mag = 32'h7FFF_FFFF;
        end else if (w_out_l[31]) begin
            w_mag = -w_out_l;
        end
        w_peak_next = (w_mag > r_peak) ? w_mag : r_peak;
    end

    always_comb begin
        w_therm = '0;
        for (int i = 0; i < 10; i++) begin
            w_therm[i] = (w_peak_next >= (32'd1 << (21 + i)));
        end
    end

    // NOTE: state registers use non-blocking assignments and clear asynchronously on RESET_N low.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
            r_peak  <= '0;
            r_ledr  <= '0;
        end else if (w_xfer) begin
            r_count <= r_count + 1'b1;
            if (r_count == {CW{1'b1}}) begin
                r_ledr <= w_therm;
                r_peak <= '0;
            end else begin
                r_peak <= w_peak_next;
            end
        end
    end
endmodule

// File: tb/tb_audio_top.sv
// Scoreboard bench for audio_top: stimulus pushes expected strobes/samples, a monitor pops and compares.
module tb_audio_top;
    localparam int WIN = 4096;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [9:0] SW;
    logic [9:0] LEDR;

    audio_top_if aud();

    audio_top #(.METER_WINDOW(WIN)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .SW       (SW),
        .aud      (aud),
        .LEDR     (LEDR)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        string       name;
        logic        strobe;
        logic [31:0] l;
        logic [31:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the response the monitor should see.
    task automatic vec(input string name, input logic av, input logic al, input logic [9:0] sw,
                       input logic [31:0] l, input logic [31:0] r,
                       input logic e_strobe, input logic [31:0] e_l, input logic [31:0] e_r);
        @(negedge CLOCK_50);
        aud.audio_in_available = av;
        aud.audio_out_allowed  = al;
        SW                     = sw;
        aud.audio_in_L         = l;
        aud.audio_in_R         = r;
        exp_q.push_back('{name, e_strobe, e_l, e_r});
    endtask

    // One full meter window; an optional special sample is preceded by a stalled cycle carrying a large value.
    task automatic run_window(input string name, input logic [31:0] fill, input int sp_idx,
                              input logic [31:0] sp_val, input logic mute,
                              input logic [9:0] prev_led, input logic [9:0] exp_led);
        for (int i = 0; i < WIN; i++) begin
            if (i == sp_idx) begin
                @(negedge CLOCK_50);
                aud.audio_in_available = 1'b1;
                aud.audio_out_allowed  = 1'b0;
                aud.audio_in_L         = 32'h7FFF_FFFF;
            end
            @(negedge CLOCK_50);
            if (i == WIN - 1) check({name, "_hold"}, {22'b0, LEDR}, {22'b0, prev_led});
            aud.audio_in_available = 1'b1;
            aud.audio_out_allowed  = 1'b1;
            SW                     = {9'b0, mute};
            aud.audio_in_L         = (i == sp_idx) ? sp_val : fill;
            aud.audio_in_R         = 32'h1234_5678;
        end
        @(negedge CLOCK_50);
        aud.audio_in_available = 1'b0;
        check(name, {22'b0, LEDR}, {22'b0, exp_led});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, "_rd"}, {31'b0, aud.read_audio_in}, {31'b0, e.strobe});
                check({e.name, "_wr"}, {31'b0, aud.write_audio_out}, {31'b0, e.strobe});
                check({e.name, "_L"}, aud.audio_out_L, e.l);
                check({e.name, "_R"}, aud.audio_out_R, e.r);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        RESET_N                = 1'b0;
        SW                     = '0;
        aud.audio_in_available = 1'b0;
        aud.audio_out_allowed  = 1'b0;
        aud.audio_in_L         = '0;
        aud.audio_in_R         = '0;

        // Datapath and handshake ignore reset; the meter output is cleared.
        vec("rst_pass", 1, 1, 10'd0, 32'd1234, 32'd5678, 1, 32'd1234, 32'd5678);
        check("rst_ledr", {22'b0, LEDR}, 32'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        vec("pass",      1, 1, 10'd0,   32'd1000, -32'sd1000, 1, 32'd1000, -32'sd1000);
        vec("mute_ext",  1, 1, 10'd1,   32'h7FFF_FFFF, 32'h8000_0000, 1, 32'd0, 32'd0);
        vec("tog0",      1, 1, 10'd0,   32'd2000, 32'd3000, 1, 32'd2000, 32'd3000);
        vec("tog1",      1, 1, 10'd1,   32'd2000, 32'd3000, 1, 32'd0, 32'd0);
        vec("tog2",      1, 1, 10'd0,   32'd2000, 32'd3000, 1, 32'd2000, 32'd3000);
        vec("mute_prio", 1, 1, 10'h00F, 32'd2000, 32'd3000, 1, 32'd0, 32'd0);
        vec("exact_ext", 1, 1, 10'd0,   32'h7FFF_FFFF, 32'h8000_0000, 1, 32'h7FFF_FFFF, 32'h8000_0000);
        vec("exact_db",  1, 1, 10'd0,   32'hDEAD_BEEF, 32'd0, 1, 32'hDEAD_BEEF, 32'd0);
        vec("hs_av_a",   1, 0, 10'd0,   32'd11, 32'd22, 0, 32'd11, 32'd22);
        vec("hs_av_b",   1, 0, 10'd0,   32'd11, 32'd22, 0, 32'd11, 32'd22);
        vec("hs_al",     0, 1, 10'd0,   32'd33, 32'd44, 0, 32'd33, 32'd44);
        vec("hs_one",    1, 1, 10'd0,   32'd55, 32'd66, 1, 32'd55, 32'd66);
        vec("hs_drop",   0, 0, 10'd0,   32'd55, 32'd66, 0, 32'd55, 32'd66);
        vec("strm0",     1, 1, 10'd0,   32'd100, 32'd200, 1, 32'd100, 32'd200);
        vec("strm1",     1, 1, 10'd0,   32'd300, 32'd400, 1, 32'd300, 32'd400);
        vec("strm2",     1, 1, 10'd0,   -32'sd500, -32'sd600, 1, -32'sd500, -32'sd600);
`ifdef AUDIO_ATTEN_EN
        vec("unused_sw", 1, 1, 10'b1111111110, 32'd7777, 32'd8888, 1, 32'd60, 32'd69);
`else
        vec("unused_sw", 1, 1, 10'b1111111110, 32'd7777, 32'd8888, 1, 32'd7777, 32'd8888);
`endif

        // Fresh meter window: clear whatever the vectors above counted.
        @(negedge CLOCK_50);
        aud.audio_in_available = 1'b0;
        SW                     = '0;
        RESET_N                = 1'b0;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        run_window("win_1ff",  32'h3FFF_FFFF, -1,   32'd0,         1'b0, 10'h000, 10'h1FF);
        run_window("win_neg",  32'd0,         1234, 32'hFFE0_0000, 1'b0, 10'h1FF, 10'h001);
        run_window("win_mute", 32'h7FFF_FFFF, -1,   32'd0,         1'b1, 10'h001, 10'h000);
        run_window("win_sat",  32'd5,         WIN - 1, 32'h8000_0000, 1'b0, 10'h000, 10'h3FF);

        // Partial window of full-scale samples, then an asynchronous reset mid-cycle.
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            aud.audio_in_available = 1'b1;
            aud.audio_out_allowed  = 1'b1;
            SW                     = '0;
            aud.audio_in_L         = 32'h7FFF_FFFF;
        end
        @(negedge CLOCK_50);
        aud.audio_in_available = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        check("rst_async", {22'b0, LEDR}, 32'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        run_window("win_post", 32'h0040_0000, -1, 32'd0, 1'b0, 10'h000, 10'h003);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLOCK_50);
        check("drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
